// File: rtl/mc_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer_if
//  Purpose  : Bundles the IR, memory handshake, mul/div status, datapath
//             strobes and counters exchanged between the multicycle
//             sequencer and the rest of the MIPS core.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_sequencer_if #(
  parameter int CNT_W = 32
);
  // Inputs to the sequencer
  logic [31:0]      instr;
  logic             imem_ready;
  logic             dmem_ready;
  logic             md_busy;

  // Requests and datapath strobes
  logic             imem_req;
  logic             dmem_req;
  logic             RegWrite;
  logic             DMwe;
  logic             PC_in;
  logic             IR_in;
  logic             A_in;
  logic             B_in;
  logic             ALUout_in;
  logic             DMout_in;
  logic             muldivWE;

  // Status and counters
  logic [3:0]       state;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic [CNT_W-1:0] stall_cnt;

  // Sequencer side
  modport master (
    input  instr, imem_ready, dmem_ready, md_busy,
    output imem_req, dmem_req, RegWrite, DMwe, PC_in, IR_in, A_in, B_in,
           ALUout_in, DMout_in, muldivWE, state, retire, instret, stall_cnt
  );

  // Datapath / memory side
  modport slave (
    output instr, imem_ready, dmem_ready, md_busy,
    input  imem_req, dmem_req, RegWrite, DMwe, PC_in, IR_in, A_in, B_in,
           ALUout_in, DMout_in, muldivWE, state, retire, instret, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer
//  Purpose  : Parametrised multicycle state sequencer for the MIPS core.
//             Walks Fetch/Decode/MA/MR/MemWB/MW/Exe/WB/Branch/Jmp, with
//             optional imem/dmem ready handshakes, a mul/div busy stall,
//             an optional HI/LO read interlock, and retire/stall counters.
//             Drives every register-load and write strobe of the datapath;
//             ALU/MUX/extension selects remain in the combinational decode.
//  Revision : 1.0  initial release
// ============================================================================
module mc_sequencer #(
  parameter int IMEM_HS        = 0,  // 1: FETCH waits for imem_ready
  parameter int DMEM_HS        = 0,  // 1: MR/MW wait for dmem_ready
  parameter int HILO_INTERLOCK = 1,  // 1: mfhi/mflo stall while md_busy
  parameter int CNT_W          = 32  // width of instret / stall_cnt
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mc_sequencer_if.master  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic c_imem_hs  = (IMEM_HS != 0);
  localparam logic c_dmem_hs  = (DMEM_HS != 0);
  localparam logic c_hilo_il  = (HILO_INTERLOCK != 0);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MA     = 4'd2,
    S_MR     = 4'd3,
    S_MEMWB  = 4'd4,
    S_MW     = 4'd5,
    S_EXE    = 4'd6,
    S_WB     = 4'd7,
    S_BRANCH = 4'd8,
    S_JMP    = 4'd9
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [5:0]       w_op;
  logic [5:0]       w_fn;
  logic [4:0]       w_rt;
  logic             w_load;
  logic             w_store;
  logic             w_branch;
  logic             w_jump;
  logic             w_link;
  logic             w_mdw;
  logic             w_hilo;
  logic             w_unused_instr;

  logic             w_fetch_done;
  logic             w_dmem_done;
  logic             w_md_stall;

  // Ungated strobes produced by the FSM; reset masking happens at the ports
  logic             w_imem_req;
  logic             w_dmem_req;
  logic             w_reg_write;
  logic             w_dm_we;
  logic             w_ir_in;
  logic             w_ab_in;
  logic             w_aluout_in;
  logic             w_dmout_in;
  logic             w_muldiv_we;
  logic             w_retire;
  logic             w_wait;

  // --------------------------------------------------------------------------
  // Instruction class decode
  // --------------------------------------------------------------------------
  assign w_op = bus.instr[31:26];
  assign w_fn = bus.instr[5:0];
  assign w_rt = bus.instr[20:16];

  // rs, rd, shamt and immediate bits do not influence sequencing
  assign w_unused_instr = ^{bus.instr[25:21], bus.instr[15:6]};

  assign w_load   = w_op inside {6'b100000, 6'b100001, 6'b100011,
                                 6'b100100, 6'b100101};
  assign w_store  = w_op inside {6'b101000, 6'b101001, 6'b101011};

  // beq/bne/blez/bgtz, plus REGIMM bltz/bgez only (the link forms are not
  // branches here and fall through to the EXE path)
  assign w_branch = (w_op[5:2] == 4'b0001) ||
                    ((w_op == 6'b000001) && ((w_rt == 5'b00000) ||
                                             (w_rt == 5'b00001)));

  assign w_jump   = (w_op == 6'b000010) || (w_op == 6'b000011) ||
                    ((w_op == 6'b000000) && ((w_fn == 6'b001000) ||
                                             (w_fn == 6'b001001)));

  assign w_link   = (w_op == 6'b000011) ||
                    ((w_op == 6'b000000) && (w_fn == 6'b001001));

  // mult/multu/div/divu and mthi/mtlo write the HI/LO unit
  assign w_mdw    = (w_op == 6'b000000) &&
                    ((w_fn[5:2] == 4'b0110) || (w_fn == 6'b010001) ||
                     (w_fn == 6'b010011));

  // mfhi/mflo read the HI/LO unit
  assign w_hilo   = (w_op == 6'b000000) &&
                    ((w_fn == 6'b010000) || (w_fn == 6'b010010));

  // --------------------------------------------------------------------------
  // Completion and stall qualifiers
  // --------------------------------------------------------------------------
  // Without a handshake the access always completes in its first cycle and
  // the ready input is don't-care.
  assign w_fetch_done = !c_imem_hs || bus.imem_ready;
  assign w_dmem_done  = !c_dmem_hs || bus.dmem_ready;
  assign w_md_stall   = bus.md_busy && (w_mdw || (w_hilo && c_hilo_il));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode from the current state and inputs
  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_reg_write = 1'b0;
    w_dm_we     = 1'b0;
    w_ir_in     = 1'b0;
    w_ab_in     = 1'b0;
    w_aluout_in = 1'b0;
    w_dmout_in  = 1'b0;
    w_muldiv_we = 1'b0;
    w_retire    = 1'b0;
    w_wait      = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_imem_req = c_imem_hs;
        w_ir_in    = w_fetch_done;
        w_wait     = !w_fetch_done;
        if (w_fetch_done) begin
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        w_ab_in = 1'b1;
        if (w_load || w_store) begin
          w_next = S_MA;
        end else if (w_branch) begin
          w_next = S_BRANCH;
        end else if (w_jump) begin
          w_next = S_JMP;
        end else begin
          w_next = S_EXE;
        end
      end

      S_MA: begin
        w_aluout_in = 1'b1;
        w_next      = w_load ? S_MR : S_MW;
      end

      S_MR: begin
        w_dmem_req = c_dmem_hs;
        w_dmout_in = w_dmem_done;
        w_wait     = !w_dmem_done;
        if (w_dmem_done) begin
          w_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end

      S_MW: begin
        // Write enable stays up through the wait; memory commits on ready
        w_dmem_req = c_dmem_hs;
        w_dm_we    = 1'b1;
        w_retire   = w_dmem_done;
        w_wait     = !w_dmem_done;
        if (w_dmem_done) begin
          w_next = S_FETCH;
        end
      end

      S_EXE: begin
        w_aluout_in = !w_md_stall;
        w_muldiv_we = w_mdw && !w_md_stall;
        w_wait      = w_md_stall;
        if (!w_md_stall) begin
          w_next = S_WB;
        end
      end

      S_WB: begin
        // HI/LO writers have no GPR destination
        w_reg_write = !w_mdw;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end

      S_BRANCH: begin
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end

      S_JMP: begin
        w_reg_write = w_link;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end

      default: begin
        // Unused encodings recover to FETCH without emitting any strobe
        w_next = S_FETCH;
      end
    endcase
  end

  // Retired-instruction and wait-cycle counters, both wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (w_wait) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: reset masks every strobe, so an abandoned access leaves no trace
  // --------------------------------------------------------------------------
  assign bus.imem_req  = !reset && w_imem_req;
  assign bus.dmem_req  = !reset && w_dmem_req;
  assign bus.RegWrite  = !reset && w_reg_write;
  assign bus.DMwe      = !reset && w_dm_we;
  assign bus.PC_in     = !reset && w_retire;
  assign bus.IR_in     = !reset && w_ir_in;
  assign bus.A_in      = !reset && w_ab_in;
  assign bus.B_in      = !reset && w_ab_in;
  assign bus.ALUout_in = !reset && w_aluout_in;
  assign bus.DMout_in  = !reset && w_dmout_in;
  assign bus.muldivWE  = !reset && w_muldiv_we;
  assign bus.retire    = !reset && w_retire;
  assign bus.state     = r_state;
  assign bus.instret   = r_instret;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
